// File: rtl/hsid_band_streamer_if.sv
// Bundles the SRAM read ports and the band-pack output of the HSID band streamer.
// Master side drives read strobes/addresses and band packs; slave side returns read data.
// Read data is expected one cycle after the strobe; the band-pack side carries no ready.
interface hsid_band_streamer_if #(
    parameter int WORD_WIDTH        = 32,
    parameter int HSP_BANDS_WIDTH   = 8,
    parameter int HSP_LIBRARY_WIDTH = 6
);
    logic                                        pixel_rd_en;
    logic [HSP_BANDS_WIDTH-2:0]                  pixel_rd_addr;
    logic [WORD_WIDTH-1:0]                       pixel_rd_data;
    logic                                        lib_rd_en;
    logic [HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH-2:0] lib_rd_addr;
    logic [WORD_WIDTH-1:0]                       lib_rd_data;
    logic [WORD_WIDTH-1:0]                       band_pack_a;
    logic [WORD_WIDTH-1:0]                       band_pack_b;
    logic                                        band_pack_valid;
    logic                                        band_pack_start;
    logic                                        band_pack_last;
    logic [HSP_LIBRARY_WIDTH-1:0]                vctr_ref;

    modport master (
        output pixel_rd_en, pixel_rd_addr, lib_rd_en, lib_rd_addr,
        input  pixel_rd_data, lib_rd_data,
        output band_pack_a, band_pack_b, band_pack_valid, band_pack_start,
        output band_pack_last, vctr_ref
    );

    modport slave (
        input  pixel_rd_en, pixel_rd_addr, lib_rd_en, lib_rd_addr,
        output pixel_rd_data, lib_rd_data,
        input  band_pack_a, band_pack_b, band_pack_valid, band_pack_start,
        input  band_pack_last, vctr_ref
    );
endinterface

// File: rtl/hsid_band_streamer.sv
// Streams pixel word + every library vector word as band packs, one pack per cycle.
// Latency: pack valid 2 cycles after its SRAM read; done 1 cycle after the final pack.
// Backpressure: none; a pass emits L*W back-to-back packs, clear aborts and flushes.
module hsid_band_streamer #(
    parameter int WORD_WIDTH        = 32,
    parameter int DATA_WIDTH        = 16,
    parameter int HSP_BANDS_WIDTH   = 8,
    parameter int HSP_LIBRARY_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsi_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsi_library_size,
    hsid_band_streamer_if.master         bus,
    output logic                         busy,
    output logic                         done
);
    localparam int AW = HSP_LIBRARY_WIDTH + HSP_BANDS_WIDTH - 1;
    localparam logic [HSP_BANDS_WIDTH-1:0]   ONE_B = 1;
    localparam logic [HSP_LIBRARY_WIDTH-1:0] ONE_L = 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_FIN} state_t;

    state_t                         state_q, state_d;
    logic [HSP_BANDS_WIDTH-2:0]     w_q, w_d;
    logic [HSP_LIBRARY_WIDTH-1:0]   ref_q, ref_d;
    logic [AW-1:0]                  base_q, base_d;
    logic [HSP_BANDS_WIDTH-1:0]     words_q, words_d;
    logic [HSP_LIBRARY_WIDTH-1:0]   lib_q, lib_d;
    logic                           odd_q, odd_d;
    logic                           drain_q, drain_d;
    // sideband stage 1 (aligned with SRAM output)
    logic                           s1_vld_q, s1_vld_d;
    logic                           s1_start_q, s1_start_d;
    logic                           s1_last_q, s1_last_d;
    logic                           s1_pad_q, s1_pad_d;
    logic [HSP_LIBRARY_WIDTH-1:0]   s1_ref_q, s1_ref_d;
    // stage 2: registered band pack
    logic [WORD_WIDTH-1:0]          pk_a_q, pk_a_d, pk_b_q, pk_b_d;
    logic                           pk_vld_q, pk_vld_d;
    logic                           pk_start_q, pk_start_d;
    logic                           pk_last_q, pk_last_d;
    logic [HSP_LIBRARY_WIDTH-1:0]   pk_ref_q, pk_ref_d;

    logic [HSP_BANDS_WIDTH:0]       bands_p1;
    logic                           last_w;

    assign bands_p1 = {1'b0, hsi_bands} + {{HSP_BANDS_WIDTH{1'b0}}, 1'b1};
    assign last_w   = ({1'b0, w_q} == (words_q - ONE_B));

    // Read strobes/addresses follow the FSM; counters sit at zero outside a pass.
    assign bus.pixel_rd_en     = (state_q == S_STREAM);
    assign bus.lib_rd_en       = (state_q == S_STREAM);
    assign bus.pixel_rd_addr   = w_q;
    assign bus.lib_rd_addr     = base_q + {{HSP_LIBRARY_WIDTH{1'b0}}, w_q};
    assign bus.band_pack_a     = pk_a_q;
    assign bus.band_pack_b     = pk_b_q;
    assign bus.band_pack_valid = pk_vld_q;
    assign bus.band_pack_start = pk_start_q;
    assign bus.band_pack_last  = pk_last_q;
    assign bus.vctr_ref        = pk_ref_q;
    assign busy                = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done                = (state_q == S_FIN);

    // Next-state, address walk, sideband pipeline and pack formatting.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        ref_d      = ref_q;
        base_d     = base_q;
        words_d    = words_q;
        lib_d      = lib_q;
        odd_d      = odd_q;
        drain_d    = drain_q;
        s1_vld_d   = 1'b0;
        s1_start_d = 1'b0;
        s1_last_d  = 1'b0;
        s1_pad_d   = 1'b0;
        s1_ref_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (hsi_bands != '0 && hsi_library_size != '0) begin
                        state_d = S_STREAM;
                        words_d = bands_p1[HSP_BANDS_WIDTH:1];
                        lib_d   = hsi_library_size;
                        odd_d   = hsi_bands[0];
                        w_d     = '0;
                        ref_d   = '0;
                        base_d  = '0;
                    end else begin
                        // empty pass: acknowledge with done only
                        state_d = S_FIN;
                    end
                end
            end
            S_STREAM: begin
                s1_vld_d   = 1'b1;
                s1_start_d = (w_q == '0);
                s1_last_d  = last_w;
                s1_pad_d   = odd_q & last_w;
                s1_ref_d   = ref_q;
                if (last_w) begin
                    w_d = '0;
                    if (ref_q == (lib_q - ONE_L)) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                        ref_d   = '0;
                        base_d  = '0;
                    end else begin
                        ref_d  = ref_q + ONE_L;
                        base_d = base_q + {{(HSP_LIBRARY_WIDTH-1){1'b0}}, words_q};
                    end
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            S_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = S_FIN;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        pk_vld_d   = s1_vld_q;
        pk_start_d = s1_vld_q & s1_start_q;
        pk_last_d  = s1_vld_q & s1_last_q;
        pk_ref_d   = s1_vld_q ? s1_ref_q : '0;
        pk_a_d     = '0;
        pk_b_d     = '0;
        if (s1_vld_q) begin
            pk_a_d = bus.pixel_rd_data;
            pk_b_d = bus.lib_rd_data;
            // odd band count: the missing band in the last word reads as zero
            if (s1_pad_q) begin
                pk_a_d[WORD_WIDTH-1:DATA_WIDTH] = '0;
                pk_b_d[WORD_WIDTH-1:DATA_WIDTH] = '0;
            end
        end

        if (clear) begin
            state_d    = S_IDLE;
            w_d        = '0;
            ref_d      = '0;
            base_d     = '0;
            drain_d    = 1'b0;
            s1_vld_d   = 1'b0;
            s1_start_d = 1'b0;
            s1_last_d  = 1'b0;
            s1_pad_d   = 1'b0;
            s1_ref_d   = '0;
            pk_vld_d   = 1'b0;
            pk_start_d = 1'b0;
            pk_last_d  = 1'b0;
            pk_ref_d   = '0;
            pk_a_d     = '0;
            pk_b_d     = '0;
        end
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            ref_q      <= '0;
            base_q     <= '0;
            words_q    <= '0;
            lib_q      <= '0;
            odd_q      <= 1'b0;
            drain_q    <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_start_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_pad_q   <= 1'b0;
            s1_ref_q   <= '0;
            pk_a_q     <= '0;
            pk_b_q     <= '0;
            pk_vld_q   <= 1'b0;
            pk_start_q <= 1'b0;
            pk_last_q  <= 1'b0;
            pk_ref_q   <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            ref_q      <= ref_d;
            base_q     <= base_d;
            words_q    <= words_d;
            lib_q      <= lib_d;
            odd_q      <= odd_d;
            drain_q    <= drain_d;
            s1_vld_q   <= s1_vld_d;
            s1_start_q <= s1_start_d;
            s1_last_q  <= s1_last_d;
            s1_pad_q   <= s1_pad_d;
            s1_ref_q   <= s1_ref_d;
            pk_a_q     <= pk_a_d;
            pk_b_q     <= pk_b_d;
            pk_vld_q   <= pk_vld_d;
            pk_start_q <= pk_start_d;
            pk_last_q  <= pk_last_d;
            pk_ref_q   <= pk_ref_d;
        end
    end
endmodule

// File: tb/tb_hsid_band_streamer.sv
// Directed bench for hsid_band_streamer with registered-read SRAM models.
// Outputs are sampled on the falling edge; inputs are driven just after it.
// Expected packs and timings are hand-derived constants.
module tb_hsid_band_streamer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic [7:0] hsi_bands = '0;
    logic [5:0] hsi_library_size = '0;
    logic       busy, done;
    int         checks = 0;
    int         errors = 0;

    logic [31:0] pix_mem [0:127];
    logic [31:0] lib_mem [0:8191];

    always #5 clk = ~clk;

    hsid_band_streamer_if #(.WORD_WIDTH(32), .HSP_BANDS_WIDTH(8), .HSP_LIBRARY_WIDTH(6)) bus ();

    hsid_band_streamer #(
        .WORD_WIDTH(32), .DATA_WIDTH(16), .HSP_BANDS_WIDTH(8), .HSP_LIBRARY_WIDTH(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .hsi_bands(hsi_bands), .hsi_library_size(hsi_library_size),
        .bus(bus), .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        if (bus.pixel_rd_en) bus.pixel_rd_data <= pix_mem[bus.pixel_rd_addr];
        if (bus.lib_rd_en)   bus.lib_rd_data   <= lib_mem[bus.lib_rd_addr];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pack(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic l, input logic [5:0] r);
        chk({tag, ".valid"}, bus.band_pack_valid, 1'b1);
        chk({tag, ".a"},     bus.band_pack_a, a);
        chk({tag, ".b"},     bus.band_pack_b, b);
        chk({tag, ".start"}, bus.band_pack_start, s);
        chk({tag, ".last"},  bus.band_pack_last, l);
        chk({tag, ".ref"},   bus.vctr_ref, r);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".prd_en"}, bus.pixel_rd_en, 1'b0);
        chk({tag, ".lrd_en"}, bus.lib_rd_en, 1'b0);
        chk({tag, ".paddr"},  bus.pixel_rd_addr, 7'd0);
        chk({tag, ".laddr"},  bus.lib_rd_addr, 13'd0);
        chk({tag, ".a"},      bus.band_pack_a, 32'd0);
        chk({tag, ".b"},      bus.band_pack_b, 32'd0);
        chk({tag, ".valid"},  bus.band_pack_valid, 1'b0);
        chk({tag, ".start"},  bus.band_pack_start, 1'b0);
        chk({tag, ".last"},   bus.band_pack_last, 1'b0);
        chk({tag, ".ref"},    bus.vctr_ref, 6'd0);
        chk({tag, ".busy"},   busy, 1'b0);
        chk({tag, ".done"},   done, 1'b0);
    endtask

    // Issue a one-cycle start; returns at the first STREAM cycle's sample point.
    task automatic kick(input logic [7:0] bands, input logic [5:0] lib);
        hsi_bands = bands;
        hsi_library_size = lib;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // bands=4, lib=2 sequence from the first STREAM cycle through done.
    task automatic run_b4_l2(input string tag);
        chk({tag, ".busy"},  busy, 1'b1);
        chk({tag, ".rd_en"}, bus.pixel_rd_en, 1'b1);
        chk({tag, ".la0"},   bus.lib_rd_addr, 13'd0);
        tick();
        chk({tag, ".v0"},    bus.band_pack_valid, 1'b0);
        chk({tag, ".pa1"},   bus.pixel_rd_addr, 7'd1);
        chk({tag, ".la1"},   bus.lib_rd_addr, 13'd1);
        tick();
        chk_pack({tag, ".p0"}, 32'hA0A0_0001, 32'hB0B0_0010, 1'b1, 1'b0, 6'd0);
        chk({tag, ".la2"},   bus.lib_rd_addr, 13'd2);
        tick();
        chk_pack({tag, ".p1"}, 32'hA0A0_0002, 32'hB0B0_0011, 1'b0, 1'b1, 6'd0);
        chk({tag, ".la3"},   bus.lib_rd_addr, 13'd3);
        tick();
        chk_pack({tag, ".p2"}, 32'hA0A0_0001, 32'hB0B0_0012, 1'b1, 1'b0, 6'd1);
        chk({tag, ".drain_rd"}, bus.lib_rd_en, 1'b0);
        chk({tag, ".drain_busy"}, busy, 1'b1);
        tick();
        chk_pack({tag, ".p3"}, 32'hA0A0_0002, 32'hB0B0_0013, 1'b0, 1'b1, 6'd1);
        chk({tag, ".done_early"}, done, 1'b0);
        tick();
        chk({tag, ".done"},   done, 1'b1);
        chk({tag, ".busy_d"}, busy, 1'b0);
        chk({tag, ".v_end"},  bus.band_pack_valid, 1'b0);
    endtask

    initial begin
        pix_mem[0] = 32'hA0A0_0001; pix_mem[1] = 32'hA0A0_0002;
        lib_mem[0] = 32'hB0B0_0010; lib_mem[1] = 32'hB0B0_0011;
        lib_mem[2] = 32'hB0B0_0012; lib_mem[3] = 32'hB0B0_0013;

        // reset state
        tick(); tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // bands=4, lib=2
        kick(8'd4, 6'd2);
        run_b4_l2("b4l2");
        tick();
        chk("b4l2.done_pulse", done, 1'b0);

        // bands=5, lib=1: third word padded on both sides
        pix_mem[2] = 32'hAAAA_5555; lib_mem[2] = 32'hAAAA_5555;
        kick(8'd5, 6'd1);
        tick();
        tick();
        chk_pack("b5.p0", 32'hA0A0_0001, 32'hB0B0_0010, 1'b1, 1'b0, 6'd0);
        tick();
        chk_pack("b5.p1", 32'hA0A0_0002, 32'hB0B0_0011, 1'b0, 1'b0, 6'd0);
        tick();
        chk_pack("b5.p2", 32'h0000_5555, 32'h0000_5555, 1'b0, 1'b1, 6'd0);
        tick();
        chk("b5.done", done, 1'b1);
        lib_mem[2] = 32'hB0B0_0012;
        tick();

        // bands=2, lib=3: W=1
        kick(8'd2, 6'd3);
        chk("w1.la0", bus.lib_rd_addr, 13'd0);
        tick();
        chk("w1.la1", bus.lib_rd_addr, 13'd1);
        tick();
        chk("w1.la2", bus.lib_rd_addr, 13'd2);
        chk_pack("w1.p0", 32'hA0A0_0001, 32'hB0B0_0010, 1'b1, 1'b1, 6'd0);
        tick();
        chk_pack("w1.p1", 32'hA0A0_0001, 32'hB0B0_0011, 1'b1, 1'b1, 6'd1);
        tick();
        chk_pack("w1.p2", 32'hA0A0_0001, 32'hB0B0_0012, 1'b1, 1'b1, 6'd2);
        tick();
        chk("w1.done", done, 1'b1);
        tick();

        // clear on the second STREAM cycle of bands=8, lib=4
        kick(8'd8, 6'd4);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr.rd_en", bus.pixel_rd_en, 1'b0);
        chk("clr.busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("clr.valid", bus.band_pack_valid, 1'b0);
            chk("clr.done", done, 1'b0);
            tick();
        end

        // empty library
        kick(8'd4, 6'd0);
        chk("lib0.done", done, 1'b1);
        chk("lib0.busy", busy, 1'b0);
        chk("lib0.rd_en", bus.pixel_rd_en, 1'b0);
        chk("lib0.valid", bus.band_pack_valid, 1'b0);
        tick();
        chk("lib0.done_pulse", done, 1'b0);
        tick();

        // start while busy ignored; input changes after start have no effect
        kick(8'd4, 6'd2);
        hsi_bands = 8'd2;
        hsi_library_size = 6'd1;
        chk("busy_st.busy", busy, 1'b1);
        tick();
        chk("busy_st.la1", bus.lib_rd_addr, 13'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_pack("busy_st.p0", 32'hA0A0_0001, 32'hB0B0_0010, 1'b1, 1'b0, 6'd0);
        tick();
        chk_pack("busy_st.p1", 32'hA0A0_0002, 32'hB0B0_0011, 1'b0, 1'b1, 6'd0);
        tick();
        chk_pack("busy_st.p2", 32'hA0A0_0001, 32'hB0B0_0012, 1'b1, 1'b0, 6'd1);
        tick();
        chk_pack("busy_st.p3", 32'hA0A0_0002, 32'hB0B0_0013, 1'b0, 1'b1, 6'd1);
        tick();
        chk("busy_st.done", done, 1'b1);

        // back-to-back: start in done cycle ignored, one cycle later accepted
        start = 1'b1;
        tick();
        chk("b2b.ignored_busy", busy, 1'b0);
        chk("b2b.ignored_rd", bus.lib_rd_en, 1'b0);
        chk("b2b.ignored_done", done, 1'b0);
        tick();
        start = 1'b0;
        chk("b2b.busy", busy, 1'b1);
        chk("b2b.rd_en", bus.lib_rd_en, 1'b1);
        tick();
        tick();
        chk_pack("b2b.p0", 32'hA0A0_0001, 32'hB0B0_0010, 1'b1, 1'b1, 6'd0);
        tick();
        chk("b2b.done", done, 1'b1);
        tick();

        // synchronous reset mid-stream, then a fresh pass from ref 0
        kick(8'd4, 6'd2);
        tick(); tick();
        chk("rst.pre_valid", bus.band_pack_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_idle_outputs("rst");
        rst_n = 1'b1;
        tick();
        chk("rst.quiet_valid", bus.band_pack_valid, 1'b0);
        kick(8'd4, 6'd2);
        run_b4_l2("rst_replay");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
